// File: rtl/sdiv_seq.sv
// Sequential signed divider: 2*DW-bit dividend / DW-bit divisor, restoring shift-subtract, one bit per clock.
// Optional feature: define SDIV_ABORT_EN to let start during busy abort and restart the division.
module sdiv_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quot,
    output logic [DW-1:0]   rem,
    output logic            ovf,
    output logic            dz,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(2*DW);
    localparam logic [CW-1:0]   LAST_CNT = CW'(2*DW-1);
    localparam logic [2*DW-1:0] QPOS_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [2*DW-1:0] QNEG_MAX = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]   SAT_POS  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   SAT_NEG  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*DW-1:0]   acc;     // dividend magnitude shifting out, quotient bits shifting in
    logic [DW-1:0]     prem;
    logic [DW-1:0]     dmag;
    logic              qsign;
    logic              rsign;
    logic              dzp;

    logic [2*DW-1:0]   dvd_mag;
    logic [DW-1:0]     dv_mag;
    logic [DW:0]       pr;
    logic [DW:0]       diff;
    logic              ge;
    logic              accept;
    logic              q_ovf;

    assign dbg_state = state;

    always_comb begin
        dvd_mag = dividend[2*DW-1] ? (~dividend + 1'b1) : dividend;
        dv_mag  = divisor[DW-1] ? (~divisor + 1'b1) : divisor;
        pr      = {prem, acc[2*DW-1]};
        ge      = (pr >= {1'b0, dmag});
        diff    = pr - {1'b0, dmag};
        q_ovf   = qsign ? (acc > QNEG_MAX) : (acc > QPOS_MAX);
`ifdef SDIV_ABORT_EN
        accept  = start;
`else
        accept  = start && (state == IDLE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            prem  <= '0;
            dmag  <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            dzp   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                acc   <= dvd_mag;
                dmag  <= dv_mag;
                prem  <= '0;
                cnt   <= '0;
                qsign <= dividend[2*DW-1] ^ divisor[DW-1];
                rsign <= dividend[2*DW-1];
                dzp   <= (divisor == '0);
                busy  <= 1'b1;
                state <= (divisor == '0) ? FIX : RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (ge) prem <= diff[DW-1:0];
                        else    prem <= pr[DW-1:0];
                        acc <= {acc[2*DW-2:0], ge};
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_CNT) state <= FIX;
                    end
                    FIX: begin
                        if (dzp) begin
                            quot <= '0;
                            rem  <= '0;
                            ovf  <= 1'b0;
                            dz   <= 1'b1;
                        end else if (q_ovf) begin
                            quot <= qsign ? SAT_NEG : SAT_POS;
                            rem  <= '0;
                            ovf  <= 1'b1;
                            dz   <= 1'b0;
                        end else begin
                            quot <= qsign ? -acc[DW-1:0] : acc[DW-1:0];
                            rem  <= rsign ? -prem : prem;
                            ovf  <= 1'b0;
                            dz   <= 1'b0;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdiv_seq.sv
// Bench for sdiv_seq: directed and random divisions against an integer-arithmetic model,
// results and done latency checked by a monitor popping an expected queue.
module tb_sdiv_seq;

    localparam int DW = 8;
    localparam int RW = 2*DW + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [2*DW-1:0] dividend = '0;
    logic [DW-1:0]   divisor = '0;
    logic            busy, done, ovf, dz;
    logic [DW-1:0]   quot, rem;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [RW-1:0] exp_q[$];
    int            lat_q[$];

    sdiv_seq #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .ovf(ovf), .dz(dz),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected {quot, rem, ovf, dz} from plain signed integer division.
    function automatic logic [RW-1:0] model(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
        int sa, sb, q, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return {8'h00, 8'h00, 1'b0, 1'b1};
        q = sa / sb;
        r = sa % sb;
        if (q > 127 || q < -128) return {(q > 0) ? 8'h7F : 8'h80, 8'h00, 1'b1, 1'b0};
        return {q[7:0], r[7:0], 1'b0, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: quot=%0h rem=%0h", cyc, quot, rem);
            end else begin
                logic [RW-1:0] e;
                int l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                chk("result", {14'd0, quot, rem, ovf, dz}, {14'd0, e});
                chk("latency", cyc, l);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%0b required 0", busy);
        end
    endtask

    task automatic issue(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
        wait_idle();
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk); #1;
        exp_q.push_back(model(a, b));
        lat_q.push_back(cyc + ((b == '0) ? 1 : 17));
        start = 1'b0;
        dividend = 16'($urandom);
        divisor = 8'($urandom);
    endtask

    initial begin
        int n;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_outs", {quot, rem, ovf, dz}, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(16'h01F4, 8'h07);
        issue(16'hFE0C, 8'h07);
        issue(16'hFE0C, 8'hF9);
        issue(16'h01F4, 8'hF9);
        issue(16'h4000, 8'h80);
        issue(16'hC000, 8'h80);
        issue(16'h1234, 8'h00);
        issue(16'h01F4, 8'h07);
        issue(16'h8000, 8'hFF);
        issue(16'h8000, 8'h01);
        issue(16'h007F, 8'h01);

        // Reset while mid-division: outputs clear at once and no done follows.
        issue(16'h01F4, 8'h07);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_outs", {quot, rem, ovf, dz}, 0);
        exp_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;

`ifndef SDIV_ABORT_EN
        // start held high: only the done cycle accepts the next operands.
        wait_idle();
        start = 1'b1;
        dividend = 16'h01F4;
        divisor = 8'h07;
        @(posedge clk); #1;
        exp_q.push_back(model(16'h01F4, 8'h07));
        lat_q.push_back(cyc + 17);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_done_seen", done, 1);
        dividend = 16'h0064;
        divisor = 8'h0A;
        @(posedge clk); #1;
        exp_q.push_back(model(16'h0064, 8'h0A));
        lat_q.push_back(cyc + 17);
        start = 1'b0;
`endif

        // start pulse at counter=3 of a running division.
        issue(16'h01F4, 8'h07);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 16'h0064;
        divisor = 8'h0A;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef SDIV_ABORT_EN
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        exp_q.push_back(model(16'h0064, 8'h0A));
        lat_q.push_back(cyc + 17);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [2*DW-1:0] a;
            logic [DW-1:0] b;
            a = 16'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'h00;
                1: a = 16'($urandom_range(0, 255));
                2: b = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'hFF;
                3: a = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
                default: ;
            endcase
            issue(a, b);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
